ser_tx_sched: RTL and testbench

- Round-robin transmit scheduler that shares one serial link between NUM_REQ parallel-word requesters.
- It drives the serial_in/lsb_in pair of the Ser2Par deserializer.
- Each granted word goes out MSB-first, one bit per clock. lsb_out is asserted with the last bit, so Ser2Par raises valid and presents the word.
- active_id tells the receive side which requester owns the word in flight.

---
 rtl/ser_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/ser_tx_sched.sv | 127 ++++++++++++
 tb/tb_ser_tx_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: shared definitions for the serial transmit scheduler.
//   state_t       - scheduler FSM encoding (idle / shifting / inter-word gap)
//   DEF_WORD_SIZE - default word width, matching the usual Ser2Par instance
//   clog2()       - constant ceil(log2(n)) used to size index/counter fields
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_WORD_SIZE = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   - request vector
//   ptr   - index of the highest-priority requester this round
//   gnt   - one-hot grant (first set req at or after ptr, wrapping)
//   idx   - binary index of the granted requester
//   any   - at least one request is pending
module rr_arbiter
  import ser_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [IDW-1:0] j;

  // Walk the ring starting at ptr; the wrap is explicit so NUM_REQ need not
  // be a power of two.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = ptr;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
      j = (j == IDW'(NUM_REQ - 1)) ? '0 : j + 1'b1;
    end
  end

endmodule

// File: rtl/ser_tx_sched.sv
// ser_tx_sched: round-robin scheduler sharing one serial link (feeding a
// Ser2Par deserializer) among NUM_REQ parallel-word requesters.
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   req        - per-requester request level, held until ack
//   req_data   - requester i word at [i*WORD_SIZE +: WORD_SIZE]
//   ack        - one-cycle pulse: requester i word captured
//   serial_out - serial bit, MSB first (to Ser2Par serial_in)
//   lsb_out    - high with the final bit (to Ser2Par lsb_in)
//   busy       - high from grant through the last gap cycle
//   active_id  - owner of the word in flight; holds when idle
module ser_tx_sched
  import ser_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0,
  localparam int IDW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           serial_out,
  output logic                           lsb_out,
  output logic                           busy,
  output logic [IDW-1:0]                 active_id
);

  localparam int CW = clog2(WORD_SIZE);
  localparam int GW = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;

  state_t                 state;
  logic [IDW-1:0]         ptr;
  logic [CW-1:0]          cnt;
  logic [GW-1:0]          gcnt;
  logic [WORD_SIZE-1:0]   sreg;
  logic [NUM_REQ-1:0]     gnt;
  logic [IDW-1:0]         gidx;
  logic                   gany;
  logic [WORD_SIZE-1:0]   gword;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // One-hot grant selects the captured word.
  always_comb begin
    gword = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gword = gword | req_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Shift register holds the bits still to be sent; the MSB goes straight to
  // serial_out at the grant edge, so the register is preloaded already
  // shifted by one. Pure datapath, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && gany) sreg <= gword << 1;
    else if (state == ST_SHIFT)   sreg <= sreg << 1;
  end

  // ---- control FSM: grant, bit count, gap, registered link outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      ack        <= '0;
      serial_out <= 1'b0;
      lsb_out    <= 1'b0;
      busy       <= 1'b0;
      active_id  <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          serial_out <= 1'b0;
          lsb_out    <= 1'b0;
          if (gany) begin
            ack        <= gnt;
            active_id  <= gidx;
            busy       <= 1'b1;
            serial_out <= gword[WORD_SIZE-1];
            cnt        <= '0;
            ptr        <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt != CW'(WORD_SIZE - 1)) begin
            cnt        <= cnt + 1'b1;
            serial_out <= sreg[WORD_SIZE-1];
            // Edge that drives bit 0 also raises lsb_out for that one cycle.
            lsb_out    <= (cnt == CW'(WORD_SIZE - 2));
          end else begin
            serial_out <= 1'b0;
            lsb_out    <= 1'b0;
            gcnt       <= '0;
            if (GAP_CYCLES > 0) begin
              state <= ST_GAP;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (int'(gcnt) >= GAP_CYCLES - 1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_tx_sched.sv
module tb_ser_tx_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req0, req3, ack0, ack3;
  logic [31:0] data0, data3;
  logic        so0, lsb0, busy0, so3, lsb3, busy3;
  logic [1:0]  aid0, aid3;

  ser_tx_sched #(.WORD_SIZE(8), .NUM_REQ(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .req_data(data0), .ack(ack0),
    .serial_out(so0), .lsb_out(lsb0), .busy(busy0), .active_id(aid0)
  );

  ser_tx_sched #(.WORD_SIZE(8), .NUM_REQ(4), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_data(data3), .ack(ack3),
    .serial_out(so3), .lsb_out(lsb3), .busy(busy3), .active_id(aid3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ser2Par receive model plus ack counters, sampled mid-cycle.
  int         cyc = 0;
  logic [7:0] sh0, sh3;
  int         w0_q[$], id0_q[$], c0_q[$];
  int         w3_q[$], id3_q[$], c3_q[$];
  int         ackc0[4], ackc3[4];

  initial begin
    sh0 = '0;
    sh3 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      sh0 = {sh0[6:0], so0};
      sh3 = {sh3[6:0], so3};
      if (lsb0) begin
        w0_q.push_back(int'(sh0)); id0_q.push_back(int'(aid0)); c0_q.push_back(cyc);
      end
      if (lsb3) begin
        w3_q.push_back(int'(sh3)); id3_q.push_back(int'(aid3)); c3_q.push_back(cyc);
      end
      for (int i = 0; i < 4; i++) begin
        if (ack0[i]) ackc0[i]++;
        if (ack3[i]) ackc3[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    w0_q.delete(); id0_q.delete(); c0_q.delete();
    w3_q.delete(); id3_q.delete(); c3_q.delete();
    for (int i = 0; i < 4; i++) begin
      ackc0[i] = 0;
      ackc3[i] = 0;
    end
  endtask

  initial begin
    int run;
    int runs[$];
    int exp_ids[4];
    reset = 1'b1;
    req0  = '0;
    req3  = '0;
    data0 = '0;
    data3 = '0;
    clr_mon();

    // Reset state, asserted between clock edges
    #3 reset = 1'b0;
    #1;
    chk("rst_serial", so0, 0);
    chk("rst_lsb", lsb0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_id", aid0, 0);
    chk("rst_busy_gap", busy3, 0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();

    // Single word A5 from requester 0
    clr_mon();
    data0 = 32'h0000_00A5;
    req0  = 4'b0001;
    tick();
    req0  = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_bit%0d", k), so0, (8'hA5 >> (7 - k)) & 1);
      chk($sformatf("t1_lsb%0d", k), lsb0, (k == 7) ? 1 : 0);
      chk($sformatf("t1_ack%0d", k), ack0, (k == 0) ? 1 : 0);
      chk($sformatf("t1_busy%0d", k), busy0, 1);
      tick();
    end
    chk("t1_end_serial", so0, 0);
    chk("t1_end_lsb", lsb0, 0);
    chk("t1_end_busy", busy0, 0);
    chk("t1_nwords", w0_q.size(), 1);
    if (w0_q.size() > 0) chk("t1_word", w0_q[0], 8'hA5);

    // Pulse reset so the round-robin pointer starts from 0 again
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // All four requesting
    clr_mon();
    data0 = 32'h4C39_2613;
    req0  = 4'hF;
    for (int n = 0; n < 80 && w0_q.size() < 4; n++) begin
      tick();
      req0 = req0 & ~ack0;
    end
    req0 = '0;
    chk("t2_nwords", w0_q.size(), 4);
    for (int i = 0; i < w0_q.size(); i++) begin
      chk($sformatf("t2_word%0d", i), w0_q[i], int'((data0 >> (8 * i)) & 32'hFF));
      chk($sformatf("t2_id%0d", i), id0_q[i], i);
      if (i > 0) chk($sformatf("t2_space%0d", i), c0_q[i] - c0_q[i-1], 9);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t2_ackc%0d", i), ackc0[i], 1);

    // Fairness wrap: requesters 0 and 3 held high
    clr_mon();
    data0 = 32'hD000_00E0;
    req0  = 4'b1001;
    for (int n = 0; n < 80 && w0_q.size() < 4; n++) tick();
    req0 = '0;
    exp_ids = '{0, 3, 0, 3};
    chk("t3_nwords", w0_q.size(), 4);
    for (int i = 0; i < w0_q.size(); i++) begin
      chk($sformatf("t3_id%0d", i), id0_q[i], exp_ids[i]);
      chk($sformatf("t3_word%0d", i), w0_q[i], (exp_ids[i] == 0) ? 8'hE0 : 8'hD0);
    end
    tick(); tick();

    // Glitching req[2] and changing req_data[0] mid-word
    clr_mon();
    data0 = 32'h0000_005A;
    req0  = 4'b0001;
    tick();
    req0  = 4'b0000;
    tick(); tick();
    req0  = 4'b0100;
    data0 = 32'h0000_0000;
    tick();
    req0  = 4'b0000;
    repeat (12) tick();
    chk("t4_nwords", w0_q.size(), 1);
    if (w0_q.size() > 0) begin
      chk("t4_word", w0_q[0], 8'h5A);
      chk("t4_id", id0_q[0], 0);
    end
    chk("t4_ack2", ackc0[2], 0);
    chk("t4_ack0", ackc0[0], 1);
    chk("t4_busy", busy0, 0);

    // Reset mid-word, then the word is resent intact from requester 0
    data0 = 32'h0000_00FF;
    req0  = 4'b0001;
    tick();
    repeat (4) tick();
    chk("t5_pre_serial", so0, 1);
    chk("t5_pre_busy", busy0, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_serial", so0, 0);
    chk("t5_rst_lsb", lsb0, 0);
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_ack", ack0, 0);
    req0  = 4'b0011;
    data0 = 32'h0000_77FF;
    clr_mon();
    tick(); tick();
    reset = 1'b1;
    for (int n = 0; n < 60 && w0_q.size() < 2; n++) begin
      tick();
      req0 = req0 & ~ack0;
    end
    req0 = '0;
    chk("t5_nwords", w0_q.size(), 2);
    if (w0_q.size() >= 2) begin
      chk("t5_word0", w0_q[0], 8'hFF);
      chk("t5_id0", id0_q[0], 0);
      chk("t5_word1", w0_q[1], 8'h77);
      chk("t5_id1", id0_q[1], 1);
    end

    // GAP_CYCLES=3, requester 1 back to back
    clr_mon();
    data3 = 32'h0000_C300;
    req3  = 4'b0010;
    tick();
    chk("t6_busy_start", busy3, 1);
    run = 0;
    for (int n = 0; n < 80 && w3_q.size() < 3; n++) begin
      tick();
      if (!busy3) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
    req3 = '0;
    chk("t6_nwords", w3_q.size(), 3);
    for (int i = 0; i < w3_q.size(); i++) begin
      chk($sformatf("t6_word%0d", i), w3_q[i], 8'hC3);
      chk($sformatf("t6_id%0d", i), id3_q[i], 1);
      if (i > 0) chk($sformatf("t6_space%0d", i), c3_q[i] - c3_q[i-1], 12);
    end
    chk("t6_nruns", runs.size(), 2);
    for (int i = 0; i < runs.size(); i++) chk($sformatf("t6_idle%0d", i), runs[i], 1);
    chk("t6_ackc1", ackc3[1], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
